// File: rtl/minimac2_slot_ctl.sv
// ============================================================================
// minimac2_slot_ctl : buffer-ownership controller (2 RX slots, 1 TX buffer)
// Revision 1.0
// ============================================================================
`default_nettype none

module minimac2_slot_ctl #(
  parameter logic [3:0] CSR_ID = 4'h0,
  parameter int         CNT_W  = 11
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [13:0]      csr_a,
  input  logic             csr_we,
  input  logic [31:0]      csr_di,
  output logic [31:0]      csr_do,
  output logic             rx_ready,
  output logic             rx_sel,
  input  logic             rx_begin,
  input  logic             rx_done,
  input  logic             rx_error,
  input  logic [CNT_W-1:0] rx_count,
  output logic             tx_start,
  output logic [CNT_W-1:0] tx_count,
  input  logic             tx_done,
  output logic             irq_rx,
  output logic             irq_tx
);

  typedef enum logic [1:0] {
    EMPTY   = 2'b00,
    LOADING = 2'b01,
    PENDING = 2'b10
  } slot_t;

  slot_t            state_q [2];
  slot_t            state_d [2];
  logic [CNT_W-1:0] count_q [2];
  logic [CNT_W-1:0] count_d [2];
  logic             rx_busy_q, rx_busy_d;
  logic             busy_slot_q, busy_slot_d;
  logic             last_fill_q, last_fill_d;
  logic             tx_busy_q, tx_busy_d;
  logic [CNT_W-1:0] tx_count_q, tx_count_d;
  logic             tx_start_q, tx_start_d;
  logic             irq_tx_q, irq_tx_d;
  logic [31:0]      csr_do_q, csr_do_d;

  logic bank_hit, csr_wr, ld0, ld1, rx_accept, tx_accept;
  logic unused_bits;

  assign unused_bits = ^{csr_a[9:3], csr_di[31:CNT_W]};

  assign bank_hit  = (csr_a[13:10] == CSR_ID);
  assign csr_wr    = csr_we & bank_hit;
  assign ld0       = (state_q[0] == LOADING);
  assign ld1       = (state_q[1] == LOADING);
  // With both slots armed, alternate away from the slot filled last.
  assign rx_sel    = (ld0 & ld1) ? ~last_fill_q : ld1;
  assign rx_ready  = (ld0 | ld1) & ~rx_busy_q;
  assign irq_rx    = (state_q[0] == PENDING) | (state_q[1] == PENDING);
  assign rx_accept = rx_begin & rx_ready;
  assign tx_accept = csr_wr & (csr_a[2:0] == 3'd4) & ~tx_busy_q & ~tx_done
                     & (csr_di[CNT_W-1:0] != '0);

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      count_d[i] = count_q[i];
    end
    rx_busy_d   = rx_busy_q;
    busy_slot_d = busy_slot_q;
    last_fill_d = last_fill_q;
    tx_busy_d   = tx_busy_q;
    tx_count_d  = tx_count_q;
    tx_start_d  = 1'b0;
    irq_tx_d    = irq_tx_q;
    csr_do_d    = '0;

    // Software may only hand back or arm a slot that the RX engine is not using.
    for (int i = 0; i < 2; i++) begin
      if (csr_wr && (csr_a[2:0] == 3'(2 * i)) && !csr_di[1]
          && !(rx_busy_q && (busy_slot_q == 1'(i)))
          && !(rx_accept && (rx_sel == 1'(i))))
        state_d[i] = slot_t'(csr_di[1:0]);
    end

    if (rx_accept) begin
      rx_busy_d   = 1'b1;
      busy_slot_d = rx_sel;
    end

    if (rx_busy_q) begin
      if (rx_error) begin
        rx_busy_d = 1'b0;
      end else if (rx_done) begin
        state_d[busy_slot_q] = PENDING;
        count_d[busy_slot_q] = rx_count;
        last_fill_d          = busy_slot_q;
        rx_busy_d            = 1'b0;
      end
    end

    if (tx_accept) begin
      tx_count_d = csr_di[CNT_W-1:0];
      tx_start_d = 1'b1;
      tx_busy_d  = 1'b1;
    end

    if (csr_wr && (csr_a[2:0] == 3'd5) && csr_di[0])
      irq_tx_d = 1'b0;

    if (tx_busy_q && tx_done) begin
      tx_busy_d  = 1'b0;
      tx_count_d = '0;
      irq_tx_d   = 1'b1;
    end

    if (bank_hit) begin
      case (csr_a[2:0])
        3'd0:    csr_do_d = {30'b0, state_q[0]};
        3'd1:    csr_do_d = {{(32-CNT_W){1'b0}}, count_q[0]};
        3'd2:    csr_do_d = {30'b0, state_q[1]};
        3'd3:    csr_do_d = {{(32-CNT_W){1'b0}}, count_q[1]};
        3'd4:    csr_do_d = {{(32-CNT_W){1'b0}}, tx_count_q};
        3'd5:    csr_do_d = {31'b0, irq_tx_q};
        default: csr_do_d = '0;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= EMPTY;
        count_q[i] <= '0;
      end
      rx_busy_q   <= 1'b0;
      busy_slot_q <= 1'b0;
      last_fill_q <= 1'b1;
      tx_busy_q   <= 1'b0;
      tx_count_q  <= '0;
      tx_start_q  <= 1'b0;
      irq_tx_q    <= 1'b0;
      csr_do_q    <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        count_q[i] <= count_d[i];
      end
      rx_busy_q   <= rx_busy_d;
      busy_slot_q <= busy_slot_d;
      last_fill_q <= last_fill_d;
      tx_busy_q   <= tx_busy_d;
      tx_count_q  <= tx_count_d;
      tx_start_q  <= tx_start_d;
      irq_tx_q    <= irq_tx_d;
      csr_do_q    <= csr_do_d;
    end
  end

  assign csr_do   = csr_do_q;
  assign tx_start = tx_start_q;
  assign tx_count = tx_count_q;
  assign irq_tx   = irq_tx_q;

endmodule

`default_nettype wire

// File: tb/tb_minimac2_slot_ctl.sv
// ============================================================================
// tb_minimac2_slot_ctl : directed self-checking bench for minimac2_slot_ctl
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_minimac2_slot_ctl;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic [13:0] csr_a = '0;
  logic        csr_we = 1'b0;
  logic [31:0] csr_di = '0;
  logic [31:0] csr_do;
  logic        rx_ready, rx_sel;
  logic        rx_begin = 1'b0, rx_done = 1'b0, rx_error = 1'b0;
  logic [10:0] rx_count = '0;
  logic        tx_start;
  logic [10:0] tx_count;
  logic        tx_done = 1'b0;
  logic        irq_rx, irq_tx;

  int checks = 0;
  int failures = 0;
  logic [31:0] rd;

  minimac2_slot_ctl #(.CSR_ID(4'h0), .CNT_W(11)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .csr_a(csr_a), .csr_we(csr_we), .csr_di(csr_di), .csr_do(csr_do),
    .rx_ready(rx_ready), .rx_sel(rx_sel),
    .rx_begin(rx_begin), .rx_done(rx_done), .rx_error(rx_error), .rx_count(rx_count),
    .tx_start(tx_start), .tx_count(tx_count), .tx_done(tx_done),
    .irq_rx(irq_rx), .irq_tx(irq_tx)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic apply_reset();
    @(negedge sys_clk); sys_rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  task automatic csr_write(input logic [3:0] bank, input logic [2:0] r, input logic [31:0] d);
    @(negedge sys_clk);
    csr_a = {bank, 7'b0, r}; csr_we = 1'b1; csr_di = d;
    @(negedge sys_clk);
    csr_we = 1'b0; csr_di = '0;
  endtask

  task automatic csr_read(input logic [3:0] bank, input logic [2:0] r, output logic [31:0] d);
    @(negedge sys_clk);
    csr_a = {bank, 7'b0, r};
    @(negedge sys_clk);
    d = csr_do;
  endtask

  task automatic rx_pulse(input logic b, input logic dn, input logic er, input logic [10:0] cnt);
    @(negedge sys_clk);
    rx_begin = b; rx_done = dn; rx_error = er; rx_count = cnt;
    @(negedge sys_clk);
    rx_begin = 1'b0; rx_done = 1'b0; rx_error = 1'b0; rx_count = '0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (rx_ready !== 1'b0) begin failures++; $display("FAIL reset_rx_ready got=%0b exp=0", rx_ready); end
    checks++; if (irq_rx !== 1'b0) begin failures++; $display("FAIL reset_irq_rx got=%0b exp=0", irq_rx); end
    checks++; if (irq_tx !== 1'b0) begin failures++; $display("FAIL reset_irq_tx got=%0b exp=0", irq_tx); end
    checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL reset_tx_start got=%0b exp=0", tx_start); end
    checks++; if (tx_count !== 11'd0) begin failures++; $display("FAIL reset_tx_count got=%0d exp=0", tx_count); end
    checks++; if (csr_do !== 32'd0) begin failures++; $display("FAIL reset_csr_do got=%0h exp=0", csr_do); end
    csr_read(4'h0, 3'd0, rd);
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL reset_state0 got=%0d exp=0", rd); end
  endtask

  task automatic test_rx_fill();
    csr_write(4'h0, 3'd0, 32'd1);
    csr_write(4'h0, 3'd2, 32'd1);
    checks++; if (rx_ready !== 1'b1) begin failures++; $display("FAIL fill_rx_ready got=%0b exp=1", rx_ready); end
    checks++; if (rx_sel !== 1'b0) begin failures++; $display("FAIL fill_rx_sel0 got=%0b exp=0", rx_sel); end
    rx_pulse(1'b1, 1'b0, 1'b0, 11'd0);
    checks++; if (rx_ready !== 1'b0) begin failures++; $display("FAIL fill_busy_ready got=%0b exp=0", rx_ready); end
    rx_pulse(1'b0, 1'b1, 1'b0, 11'd64);
    csr_read(4'h0, 3'd0, rd);
    checks++; if (rd !== 32'd2) begin failures++; $display("FAIL fill_state0 got=%0d exp=2", rd); end
    csr_read(4'h0, 3'd1, rd);
    checks++; if (rd !== 32'd64) begin failures++; $display("FAIL fill_count0 got=%0d exp=64", rd); end
    checks++; if (irq_rx !== 1'b1) begin failures++; $display("FAIL fill_irq_rx got=%0b exp=1", irq_rx); end
    checks++; if (rx_sel !== 1'b1) begin failures++; $display("FAIL fill_rx_sel1 got=%0b exp=1", rx_sel); end
  endtask

  task automatic test_lock_and_error();
    csr_write(4'h0, 3'd2, 32'd0);
    csr_write(4'h0, 3'd0, 32'd1);
    checks++; if (rx_sel !== 1'b0) begin failures++; $display("FAIL lock_rx_sel got=%0b exp=0", rx_sel); end
    rx_pulse(1'b1, 1'b0, 1'b0, 11'd0);
    csr_write(4'h0, 3'd0, 32'd0);
    csr_read(4'h0, 3'd0, rd);
    checks++; if (rd !== 32'd1) begin failures++; $display("FAIL lock_state0 got=%0d exp=1", rd); end
    rx_pulse(1'b0, 1'b0, 1'b1, 11'd0);
    csr_read(4'h0, 3'd0, rd);
    checks++; if (rd !== 32'd1) begin failures++; $display("FAIL err_state0 got=%0d exp=1", rd); end
    csr_read(4'h0, 3'd1, rd);
    checks++; if (rd !== 32'd64) begin failures++; $display("FAIL err_count0 got=%0d exp=64", rd); end
    checks++; if (rx_ready !== 1'b1) begin failures++; $display("FAIL err_rx_ready got=%0b exp=1", rx_ready); end
    rx_pulse(1'b1, 1'b0, 1'b0, 11'd0);
    rx_pulse(1'b0, 1'b1, 1'b1, 11'd5);
    csr_read(4'h0, 3'd0, rd);
    checks++; if (rd !== 32'd1) begin failures++; $display("FAIL both_state0 got=%0d exp=1", rd); end
    csr_read(4'h0, 3'd1, rd);
    checks++; if (rd !== 32'd64) begin failures++; $display("FAIL both_count0 got=%0d exp=64", rd); end
    rx_pulse(1'b0, 1'b1, 1'b0, 11'd7);
    csr_read(4'h0, 3'd0, rd);
    checks++; if (rd !== 32'd1) begin failures++; $display("FAIL idle_done_state0 got=%0d exp=1", rd); end
  endtask

  task automatic test_tx();
    csr_write(4'h0, 3'd4, 32'd100);
    checks++; if (tx_start !== 1'b1) begin failures++; $display("FAIL tx_start_hi got=%0b exp=1", tx_start); end
    checks++; if (tx_count !== 11'd100) begin failures++; $display("FAIL tx_count got=%0d exp=100", tx_count); end
    @(negedge sys_clk);
    checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL tx_start_lo got=%0b exp=0", tx_start); end
    csr_write(4'h0, 3'd4, 32'd50);
    checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL tx_busy_start got=%0b exp=0", tx_start); end
    checks++; if (tx_count !== 11'd100) begin failures++; $display("FAIL tx_busy_count got=%0d exp=100", tx_count); end
    @(negedge sys_clk); tx_done = 1'b1;
    @(negedge sys_clk); tx_done = 1'b0;
    checks++; if (irq_tx !== 1'b1) begin failures++; $display("FAIL tx_irq_set got=%0b exp=1", irq_tx); end
    checks++; if (tx_count !== 11'd0) begin failures++; $display("FAIL tx_done_count got=%0d exp=0", tx_count); end
    csr_read(4'h0, 3'd5, rd);
    checks++; if (rd !== 32'd1) begin failures++; $display("FAIL tx_irqstat got=%0d exp=1", rd); end
    csr_write(4'h0, 3'd5, 32'd1);
    checks++; if (irq_tx !== 1'b0) begin failures++; $display("FAIL tx_irq_clr got=%0b exp=0", irq_tx); end
    csr_write(4'h0, 3'd4, 32'd0);
    checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL tx_zero_start got=%0b exp=0", tx_start); end
    csr_write(4'h0, 3'd4, 32'd30);
    @(negedge sys_clk);
    csr_a = {4'h0, 7'b0, 3'd5}; csr_we = 1'b1; csr_di = 32'd1; tx_done = 1'b1;
    @(negedge sys_clk);
    csr_we = 1'b0; csr_di = '0; tx_done = 1'b0;
    checks++; if (irq_tx !== 1'b1) begin failures++; $display("FAIL tx_set_wins got=%0b exp=1", irq_tx); end
    checks++; if (tx_count !== 11'd0) begin failures++; $display("FAIL tx_done2_count got=%0d exp=0", tx_count); end
  endtask

  task automatic test_alternate();
    apply_reset();
    csr_write(4'h0, 3'd0, 32'd1);
    csr_write(4'h0, 3'd2, 32'd1);
    checks++; if (rx_sel !== 1'b0) begin failures++; $display("FAIL alt_sel_first got=%0b exp=0", rx_sel); end
    rx_pulse(1'b1, 1'b0, 1'b0, 11'd0);
    rx_pulse(1'b0, 1'b1, 1'b0, 11'd10);
    checks++; if (rx_sel !== 1'b1) begin failures++; $display("FAIL alt_sel_second got=%0b exp=1", rx_sel); end
    rx_pulse(1'b1, 1'b0, 1'b0, 11'd0);
    rx_pulse(1'b0, 1'b1, 1'b0, 11'd20);
    csr_read(4'h0, 3'd2, rd);
    checks++; if (rd !== 32'd2) begin failures++; $display("FAIL alt_state1 got=%0d exp=2", rd); end
    csr_read(4'h0, 3'd3, rd);
    checks++; if (rd !== 32'd20) begin failures++; $display("FAIL alt_count1 got=%0d exp=20", rd); end
    checks++; if (rx_ready !== 1'b0) begin failures++; $display("FAIL alt_none_ready got=%0b exp=0", rx_ready); end
    csr_write(4'h0, 3'd2, 32'd1);
    checks++; if (rx_sel !== 1'b1) begin failures++; $display("FAIL alt_only1_sel got=%0b exp=1", rx_sel); end
    checks++; if (rx_ready !== 1'b1) begin failures++; $display("FAIL alt_only1_ready got=%0b exp=1", rx_ready); end
    csr_write(4'h0, 3'd0, 32'd1);
    checks++; if (rx_sel !== 1'b0) begin failures++; $display("FAIL alt_both_sel got=%0b exp=0", rx_sel); end
  endtask

  task automatic test_reset_midframe();
    rx_pulse(1'b1, 1'b0, 1'b0, 11'd0);
    apply_reset();
    checks++; if (rx_ready !== 1'b0) begin failures++; $display("FAIL mid_rx_ready got=%0b exp=0", rx_ready); end
    checks++; if (irq_rx !== 1'b0) begin failures++; $display("FAIL mid_irq_rx got=%0b exp=0", irq_rx); end
    csr_read(4'h0, 3'd1, rd);
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL mid_count0 got=%0d exp=0", rd); end
    rx_pulse(1'b0, 1'b1, 1'b0, 11'd99);
    csr_read(4'h0, 3'd0, rd);
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL mid_late_state0 got=%0d exp=0", rd); end
    csr_read(4'h0, 3'd1, rd);
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL mid_late_count0 got=%0d exp=0", rd); end
    checks++; if (irq_rx !== 1'b0) begin failures++; $display("FAIL mid_late_irq got=%0b exp=0", irq_rx); end
  endtask

  task automatic test_csr_misc();
    csr_write(4'h0, 3'd2, 32'd2);
    csr_read(4'h0, 3'd2, rd);
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL misc_state1_w2 got=%0d exp=0", rd); end
    csr_write(4'h0, 3'd2, 32'd3);
    csr_read(4'h0, 3'd2, rd);
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL misc_state1_w3 got=%0d exp=0", rd); end
    csr_write(4'h5, 3'd0, 32'd1);
    csr_read(4'h0, 3'd0, rd);
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL misc_bank_write got=%0d exp=0", rd); end
    csr_write(4'h0, 3'd2, 32'd1);
    rx_pulse(1'b1, 1'b0, 1'b0, 11'd0);
    rx_pulse(1'b0, 1'b1, 1'b0, 11'd33);
    csr_read(4'h0, 3'd3, rd);
    checks++; if (rd !== 32'd33) begin failures++; $display("FAIL misc_count1 got=%0d exp=33", rd); end
    csr_read(4'h5, 3'd3, rd);
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL misc_bank_read got=%0d exp=0", rd); end
  endtask

  initial begin
    test_reset();
    test_rx_fill();
    test_lock_and_error();
    test_tx();
    test_alternate();
    test_reset_midframe();
    test_csr_misc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
